// File: rtl/gemb_pkg.sv
// Shared loader types and constants for the program-loader slice.
package gemb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } loader_state_t;

   localparam logic [7:0] LDR_HEADER = 8'hA5;
   localparam int         PROG_DEPTH = 16384;

endpackage

// File: rtl/prog_store.sv
// DEPTH x 8 program store: synchronous write, asynchronous read.
module prog_store #(
   parameter int DEPTH  = 16384,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK100MHZ,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   // No reset: contents must survive rst so a partial image stays visible.
   logic [7:0] mem [DEPTH];

   always_ff @(posedge CLK100MHZ) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Framed serial program loader feeding the processor's external program port.
// Optional trailing checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
   import gemb_pkg::*;
#(
   parameter int         DEPTH  = PROG_DEPTH,
   parameter int         ADDR_W = $clog2(DEPTH),
   parameter logic [7:0] HEADER = LDR_HEADER
) (
   input  logic        CLK100MHZ,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic [15:0] ExternalIndex,
   output logic [7:0]  ExternalData,
   output logic        cpu_rst,
   output logic        load_done,
   output logic        load_err
);

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam loader_state_t LAST_ST = CSUM;
`else
   localparam loader_state_t LAST_ST = DONE;
`endif

   loader_state_t state;
   logic [15:0]   wr_ptr;
   logic [15:0]   len;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]    sum;
`endif
   logic          xfer;
   logic          is_hdr;
   logic [16:0]   len_in;
   logic          we;
   logic [7:0]    rdata;

   assign rx_ready  = ~rst;
   assign xfer      = rx_valid & rx_ready;
   assign is_hdr    = (rx_data == HEADER);
   // One extra bit so LEN values above DEPTH compare correctly for any DEPTH.
   assign len_in    = {1'b0, rx_data, len[7:0]};
   assign we        = xfer && (state == DATA);
   assign cpu_rst   = (state != DONE);
   assign load_done = (state == DONE);

   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         len      <= '0;
         load_err <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum      <= '0;
`endif
      end else if (state == ERR) begin
         // ERR lasts exactly one cycle; a byte landing here is dropped.
         state <= IDLE;
      end else if (xfer) begin
         case (state)
            IDLE, DONE: begin
               if (is_hdr) begin
                  state    <= LEN_LO;
                  load_err <= 1'b0;
                  wr_ptr   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  sum      <= '0;
`endif
               end
            end
            LEN_LO: begin
               len[7:0] <= rx_data;
               state    <= LEN_HI;
            end
            LEN_HI: begin
               len[15:8] <= rx_data;
               if (len_in > 17'(DEPTH)) begin
                  state    <= ERR;
                  load_err <= 1'b1;
               end else if (len_in == 17'd0) begin
                  state <= LAST_ST;
               end else begin
                  state <= DATA;
               end
            end
            DATA: begin
               wr_ptr <= wr_ptr + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum    <= sum + rx_data;
`endif
               if (wr_ptr + 16'd1 == len) state <= LAST_ST;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: begin
               if (rx_data == sum) begin
                  state <= DONE;
               end else begin
                  state    <= ERR;
                  load_err <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   prog_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_store (
      .CLK100MHZ (CLK100MHZ),
      .we        (we),
      .waddr     (wr_ptr[ADDR_W-1:0]),
      .wdata     (rx_data),
      .raddr     (ExternalIndex[ADDR_W-1:0]),
      .rdata     (rdata)
   );

   assign ExternalData = ({1'b0, ExternalIndex} < 17'(DEPTH)) ? rdata : 8'h00;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader; follows PROG_LOADER_CHECKSUM_EN when defined.
module tb_prog_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] ExternalIndex;
   logic [7:0]  ExternalData;
   logic        cpu_rst;
   logic        load_done;
   logic        load_err;

   int checks;
   int errors;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] model [16384];

   prog_loader dut (
      .CLK100MHZ     (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .ExternalIndex (ExternalIndex),
      .ExternalData  (ExternalData),
      .cpu_rst       (cpu_rst),
      .load_done     (load_done),
      .load_err      (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      idle(gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   // Sends HEADER, LEN, data, (CSUM); updates model and scoreboard; checks release timing.
   task automatic send_frame(input logic [7:0] d[$], input bit bad, input int maxgap);
      logic [7:0]  b[$];
      logic [7:0]  s;
      logic [15:0] n;
      logic [7:0]  last;
      s = 8'h00;
      n = 16'(d.size());
      b.push_back(8'hA5);
      b.push_back(n[7:0]);
      b.push_back(n[15:8]);
      foreach (d[i]) begin
         b.push_back(d[i]);
         s = s + d[i];
         model[i] = d[i];
         sb_q.push_back('{16'(i), d[i]});
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      b.push_back(bad ? (s ^ 8'h01) : s);
`endif
      last = b.pop_back();
      foreach (b[i]) send_byte(b[i], $urandom_range(0, maxgap));
      idle($urandom_range(0, maxgap));
      checks++;
      if (cpu_rst !== 1'b1) begin
         $display("FAIL cpu_rst_before_last: got %b expected 1", cpu_rst);
         errors++;
      end
      send_byte(last, 0);
      checks++;
      if (cpu_rst !== bad) begin
         $display("FAIL cpu_rst_after_last: got %b expected %b", cpu_rst, bad);
         errors++;
      end
      checks++;
      if (load_done !== !bad) begin
         $display("FAIL load_done_after_last: got %b expected %b", load_done, !bad);
         errors++;
      end
   endtask

   task automatic check_store();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         ExternalIndex = e.a;
         #1;
         checks++;
         if (ExternalData !== e.d) begin
            $display("FAIL store[%0d]: got %h expected %h", e.a, ExternalData, e.d);
            errors++;
         end
      end
      ExternalIndex = 16'd0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      ExternalIndex = 16'd0;
      idle(2);
      checks++;
      if (cpu_rst !== 1'b1) begin $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); errors++; end
      checks++;
      if (rx_ready !== 1'b0) begin $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); errors++; end
      checks++;
      if (load_done !== 1'b0) begin $display("FAIL reset_load_done: got %b expected 0", load_done); errors++; end
      checks++;
      if (load_err !== 1'b0) begin $display("FAIL reset_load_err: got %b expected 0", load_err); errors++; end
      rst = 1'b0;
      idle(1);
      checks++;
      if (rx_ready !== 1'b1) begin $display("FAIL post_reset_rx_ready: got %b expected 1", rx_ready); errors++; end
   endtask

   task automatic test_good_frame();
      logic [7:0] d[$];
      d = '{8'h11, 8'h22, 8'h33};
      send_frame(d, 1'b0, 0);
      check_store();
      ExternalIndex = 16'd16384;
      #1;
      checks++;
      if (ExternalData !== 8'h00) begin $display("FAIL out_of_range_16384: got %h expected 00", ExternalData); errors++; end
      ExternalIndex = 16'hFFFF;
      #1;
      checks++;
      if (ExternalData !== 8'h00) begin $display("FAIL out_of_range_ffff: got %h expected 00", ExternalData); errors++; end
      ExternalIndex = 16'd0;
      idle(1);
   endtask

   task automatic test_bad_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
      logic [7:0] d[$];
      d = '{8'h7F};
      send_frame(d, 1'b1, 0);
      idle(2);
      checks++;
      if (load_err !== 1'b1) begin $display("FAIL bad_csum_load_err: got %b expected 1", load_err); errors++; end
      checks++;
      if (cpu_rst !== 1'b1) begin $display("FAIL bad_csum_cpu_rst: got %b expected 1", cpu_rst); errors++; end
      check_store();
      d = '{8'($urandom), 8'($urandom)};
      send_frame(d, 1'b0, 2);
      checks++;
      if (load_err !== 1'b0) begin $display("FAIL recover_load_err: got %b expected 0", load_err); errors++; end
      check_store();
`endif
   endtask

   task automatic test_overflow();
      logic [7:0] keep;
      keep = model[0];
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h40, 0);
      send_byte(8'h99, 0);
      send_byte(8'h77, 1);
      idle(2);
      checks++;
      if (load_err !== 1'b1) begin $display("FAIL overflow_load_err: got %b expected 1", load_err); errors++; end
      checks++;
      if (cpu_rst !== 1'b1) begin $display("FAIL overflow_cpu_rst: got %b expected 1", cpu_rst); errors++; end
      checks++;
      if (load_done !== 1'b0) begin $display("FAIL overflow_load_done: got %b expected 0", load_done); errors++; end
      ExternalIndex = 16'd0;
      #1;
      checks++;
      if (ExternalData !== keep) begin $display("FAIL overflow_no_write: got %h expected %h", ExternalData, keep); errors++; end
      idle(1);
   endtask

   task automatic test_full_depth();
      logic [7:0] d[$];
      for (int i = 0; i < 16384; i++) d.push_back(8'(i * 7 + 3));
      send_frame(d, 1'b0, 0);
      checks++;
      if (load_err !== 1'b0) begin $display("FAIL full_depth_load_err: got %b expected 0", load_err); errors++; end
      check_store();
   endtask

   task automatic test_reload_reset();
      logic [7:0] d;
      send_byte(8'hA5, 0);
      checks++;
      if (cpu_rst !== 1'b1) begin $display("FAIL reload_cpu_rst: got %b expected 1", cpu_rst); errors++; end
      checks++;
      if (load_done !== 1'b0) begin $display("FAIL reload_load_done: got %b expected 0", load_done); errors++; end
      send_byte(8'h08, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom);
         model[i] = d;
         sb_q.push_back('{16'(i), d});
         send_byte(d, $urandom_range(0, 2));
      end
      // Byte offered in the reset cycle must not reach the store.
      sb_q.push_back('{16'd3, model[3]});
      rx_data  = ~model[3];
      rx_valid = 1'b1;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rst      = 1'b0;
      idle(1);
      checks++;
      if (cpu_rst !== 1'b1) begin $display("FAIL midload_reset_cpu_rst: got %b expected 1", cpu_rst); errors++; end
      checks++;
      if (load_done !== 1'b0) begin $display("FAIL midload_reset_load_done: got %b expected 0", load_done); errors++; end
      check_store();
   endtask

   task automatic test_noise_gaps();
      logic [7:0] d[$];
      send_byte(8'h00, 1);
      send_byte(8'hFF, 0);
      send_byte(8'h5A, 3);
      idle(1);
      checks++;
      if (cpu_rst !== 1'b1) begin $display("FAIL noise_cpu_rst: got %b expected 1", cpu_rst); errors++; end
      checks++;
      if (load_done !== 1'b0) begin $display("FAIL noise_load_done: got %b expected 0", load_done); errors++; end
      d = '{};
      for (int i = 0; i < 5; i++) d.push_back(8'($urandom));
      send_frame(d, 1'b0, 4);
      check_store();
      d = '{8'hA5, 8'hA5};
      send_frame(d, 1'b0, 2);
      check_store();
      d = '{};
      send_frame(d, 1'b0, 1);
      checks++;
      if (load_err !== 1'b0) begin $display("FAIL zero_len_load_err: got %b expected 0", load_err); errors++; end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_overflow();
      test_full_depth();
      test_reload_reset();
      test_noise_gaps();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
